// File: rtl/alarm_ringer.sv
// -----------------------------------------------------------------------------
// alarm_ringer
// -----------------------------------------------------------------------------
// Purpose:
//   Compares the stored alarm time (BCD hour/minute) with the running clock and
//   rings the buzzer for a bounded period. The ring can be stopped or snoozed
//   a limited number of times per alarm event. The buzzer beeps 1 s on / 1 s
//   off while ringing, starting with the on phase.
//
// Optional build macro:
//   HOURLY_CHIME_EN - when defined, a 2 s buzzer chime sounds at mm:ss = 00:00
//                     and 00:01 while idle, independent of alarm_on.
//
// Ports:
//   clk          in   system clock
//   cr           in   synchronous active-high reset
//   tick_1hz     in   one-clk pulse per second
//   alarm_on     in   alarm armed switch (level)
//   cur_hour     in   current hour   (BCD)
//   cur_minute   in   current minute (BCD)
//   cur_second   in   current second (BCD)
//   alarm_hour   in   alarm hour     (BCD)
//   alarm_minute in   alarm minute   (BCD)
//   stop_key     in   one-clk pulse, silence the alarm
//   snooze_key   in   one-clk pulse, snooze the alarm
//   buzzer       out  buzzer drive (registered)
//   ringing      out  high while ringing (registered)
//   snoozing     out  high while snoozing (registered)
//   snooze_left  out  snoozes remaining for the current alarm event
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module alarm_ringer #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic       clk,
  input  logic       cr,
  input  logic       tick_1hz,
  input  logic       alarm_on,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_minute,
  input  logic [7:0] cur_second,
  input  logic [7:0] alarm_hour,
  input  logic [7:0] alarm_minute,
  input  logic       stop_key,
  input  logic       snooze_key,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [2:0] snooze_left
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

  localparam logic [9:0] RING_LAST   = 10'(RING_SECONDS - 1);
  localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_SECONDS - 1);
  localparam logic [2:0] SNOOZE_MAX  = 3'(MAX_SNOOZE);

  state_t     state_q, state_d;
  logic [9:0] sec_cnt_q, sec_cnt_d;
  logic       beep_phase_q, beep_phase_d;
  logic [2:0] snooze_left_q, snooze_left_d;
  logic       match_q;
  logic       ringing_q, ringing_d;
  logic       snoozing_q, snoozing_d;
  logic       buzzer_q, buzzer_d;

  logic match;
  logic trigger;

  // Raw BCD equality; the alarm fires only at second 00 of the alarm minute.
  assign match = alarm_on
               & (cur_hour   == alarm_hour)
               & (cur_minute == alarm_minute)
               & (cur_second == 8'h00);

  // Rising edge of match: one trigger per alarm minute even if time is held.
  assign trigger = match & ~match_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    sec_cnt_d     = sec_cnt_q;
    beep_phase_d  = beep_phase_q;
    snooze_left_d = snooze_left_q;

    case (state_q)
      ST_IDLE: begin
        snooze_left_d = SNOOZE_MAX;
        if (trigger) begin
          state_d      = ST_RING;
          sec_cnt_d    = '0;
          beep_phase_d = 1'b1;
        end
      end

      ST_RING: begin
        if (!alarm_on || stop_key) begin
          state_d       = ST_IDLE;
          sec_cnt_d     = '0;
          beep_phase_d  = 1'b0;
          snooze_left_d = SNOOZE_MAX;
        end else if (snooze_key && (snooze_left_q != 3'd0)) begin
          state_d       = ST_SNOOZE;
          sec_cnt_d     = '0;
          snooze_left_d = snooze_left_q - 3'd1;
        end else if (tick_1hz) begin
          // An exhausted snooze key falls through to here, so it is ignored.
          if (sec_cnt_q == RING_LAST) begin
            state_d       = ST_IDLE;
            sec_cnt_d     = '0;
            beep_phase_d  = 1'b0;
            snooze_left_d = SNOOZE_MAX;
          end else begin
            sec_cnt_d    = sec_cnt_q + 10'd1;
            beep_phase_d = ~beep_phase_q;
          end
        end
      end

      ST_SNOOZE: begin
        if (!alarm_on || stop_key) begin
          state_d       = ST_IDLE;
          sec_cnt_d     = '0;
          beep_phase_d  = 1'b0;
          snooze_left_d = SNOOZE_MAX;
        end else if (tick_1hz) begin
          if (sec_cnt_q == SNOOZE_LAST) begin
            // Re-ring without reloading the snooze allowance.
            state_d      = ST_RING;
            sec_cnt_d    = '0;
            beep_phase_d = 1'b1;
          end else begin
            sec_cnt_d = sec_cnt_q + 10'd1;
          end
        end
      end

      default: begin
        state_d       = ST_IDLE;
        sec_cnt_d     = '0;
        beep_phase_d  = 1'b0;
        snooze_left_d = SNOOZE_MAX;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output next values, taken from the next state so the registered outputs
  // follow the state register with the same edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    ringing_d  = (state_d == ST_RING);
    snoozing_d = (state_d == ST_SNOOZE);
    buzzer_d   = ringing_d & beep_phase_d;
`ifdef HOURLY_CHIME_EN
    if ((state_d == ST_IDLE) && (cur_minute == 8'h00) &&
        ((cur_second == 8'h00) || (cur_second == 8'h01))) begin
      buzzer_d = 1'b1;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (cr) begin
      state_q       <= ST_IDLE;
      sec_cnt_q     <= '0;
      beep_phase_q  <= 1'b0;
      snooze_left_q <= SNOOZE_MAX;
      match_q       <= 1'b0;
      ringing_q     <= 1'b0;
      snoozing_q    <= 1'b0;
      buzzer_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      sec_cnt_q     <= sec_cnt_d;
      beep_phase_q  <= beep_phase_d;
      snooze_left_q <= snooze_left_d;
      match_q       <= match;
      ringing_q     <= ringing_d;
      snoozing_q    <= snoozing_d;
      buzzer_q      <= buzzer_d;
    end
  end

  assign buzzer      = buzzer_q;
  assign ringing     = ringing_q;
  assign snoozing    = snoozing_q;
  assign snooze_left = snooze_left_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// -----------------------------------------------------------------------------
// tb_alarm_ringer
// -----------------------------------------------------------------------------
// Directed testbench for alarm_ringer with default parameters (60 s ring,
// 300 s snooze, 3 snoozes). Outputs are observed as the packed vector
// {ringing, snoozing, buzzer, snooze_left[2:0]} one time unit after each edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_alarm_ringer;

  logic       clk = 1'b0;
  logic       cr;
  logic       tick_1hz;
  logic       alarm_on;
  logic [7:0] cur_hour, cur_minute, cur_second;
  logic [7:0] alarm_hour, alarm_minute;
  logic       stop_key, snooze_key;
  logic       buzzer, ringing, snoozing;
  logic [2:0] snooze_left;

  logic [5:0] obs;
  assign obs = {ringing, snoozing, buzzer, snooze_left};

  int checks = 0;
  int errors = 0;

`ifdef HOURLY_CHIME_EN
  localparam logic CHIME = 1'b1;
`else
  localparam logic CHIME = 1'b0;
`endif

  always #5 clk = ~clk;

  alarm_ringer dut (
    .clk          (clk),
    .cr           (cr),
    .tick_1hz     (tick_1hz),
    .alarm_on     (alarm_on),
    .cur_hour     (cur_hour),
    .cur_minute   (cur_minute),
    .cur_second   (cur_second),
    .alarm_hour   (alarm_hour),
    .alarm_minute (alarm_minute),
    .stop_key     (stop_key),
    .snooze_key   (snooze_key),
    .buzzer       (buzzer),
    .ringing      (ringing),
    .snoozing     (snoozing),
    .snooze_left  (snooze_left)
  );

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    step();
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    cur_hour   = h;
    cur_minute = m;
    cur_second = s;
  endtask

  task automatic do_reset();
    cr = 1'b1;
    set_time(8'h07, 8'h29, 8'h59);
    step();
    cr = 1'b0;
  endtask

  // Arms the alarm and advances the clock onto 07:30:00; ringing starts at
  // the edge that ends this task.
  task automatic start_ring();
    alarm_on = 1'b1;
    set_time(8'h07, 8'h29, 8'h59);
    step();
    set_time(8'h07, 8'h30, 8'h00);
    step();
  endtask

  task automatic press_snooze();
    snooze_key = 1'b1;
    step();
    snooze_key = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    cr = 1'b1;
    step();
    checks++;
    if (obs !== 6'b000_011) begin
      errors++;
      $display("FAIL reset_values: got %b expected %b", obs, 6'b000_011);
    end
    cr = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_ring_timeout();
    logic exp_buz;
    do_reset();
    start_ring();
    checks++;
    if (obs !== 6'b101_011) begin
      errors++;
      $display("FAIL ring_start: got %b expected %b", obs, 6'b101_011);
    end
    for (int n = 1; n <= 59; n++) begin
      tick();
      exp_buz = ((n % 2) == 0);
      checks++;
      if (obs !== {1'b1, 1'b0, exp_buz, 3'd3}) begin
        errors++;
        $display("FAIL ring_beep tick %0d: got %b expected %b", n, obs, {1'b1, 1'b0, exp_buz, 3'd3});
      end
    end
    tick();
    checks++;
    if (obs !== 6'b000_011) begin
      errors++;
      $display("FAIL ring_timeout: got %b expected %b", obs, 6'b000_011);
    end
    $display("test_ring_timeout done");
  endtask

  task automatic test_stop();
    do_reset();
    start_ring();
    for (int n = 0; n < 5; n++) tick();
    stop_key = 1'b1;
    step();
    stop_key = 1'b0;
    checks++;
    if (obs !== 6'b000_011) begin
      errors++;
      $display("FAIL stop_key: got %b expected %b", obs, 6'b000_011);
    end
    // Time remains 07:30:00; the match level must not retrigger.
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (obs !== 6'b000_011) begin
        errors++;
        $display("FAIL no_retrigger %0d: got %b expected %b", n, obs, 6'b000_011);
      end
    end
    $display("test_stop done");
  endtask

  task automatic test_snooze();
    logic [2:0] left;
    do_reset();
    start_ring();
    for (int r = 0; r < 3; r++) begin
      left = 3'(2 - r);
      press_snooze();
      checks++;
      if (obs !== {1'b0, 1'b1, 1'b0, left}) begin
        errors++;
        $display("FAIL snooze_enter %0d: got %b expected %b", r, obs, {1'b0, 1'b1, 1'b0, left});
      end
      if (r == 0) begin
        press_snooze();
        checks++;
        if (obs !== {1'b0, 1'b1, 1'b0, left}) begin
          errors++;
          $display("FAIL snooze_in_snooze: got %b expected %b", obs, {1'b0, 1'b1, 1'b0, left});
        end
      end
      for (int n = 0; n < 299; n++) tick();
      checks++;
      if (obs !== {1'b0, 1'b1, 1'b0, left}) begin
        errors++;
        $display("FAIL snooze_wait %0d: got %b expected %b", r, obs, {1'b0, 1'b1, 1'b0, left});
      end
      tick();
      checks++;
      if (obs !== {1'b1, 1'b0, 1'b1, left}) begin
        errors++;
        $display("FAIL snooze_rering %0d: got %b expected %b", r, obs, {1'b1, 1'b0, 1'b1, left});
      end
      $display("snooze round %0d done", r);
    end
    press_snooze();
    checks++;
    if (obs !== 6'b101_000) begin
      errors++;
      $display("FAIL snooze_exhausted: got %b expected %b", obs, 6'b101_000);
    end
    for (int n = 0; n < 59; n++) tick();
    checks++;
    if (obs !== 6'b100_000) begin
      errors++;
      $display("FAIL exhausted_ring_59: got %b expected %b", obs, 6'b100_000);
    end
    tick();
    checks++;
    if (obs !== 6'b000_011) begin
      errors++;
      $display("FAIL exhausted_timeout: got %b expected %b", obs, 6'b000_011);
    end
    $display("test_snooze done");
  endtask

  task automatic test_stop_and_snooze();
    do_reset();
    start_ring();
    tick();
    stop_key   = 1'b1;
    snooze_key = 1'b1;
    step();
    stop_key   = 1'b0;
    snooze_key = 1'b0;
    checks++;
    if (obs !== 6'b000_011) begin
      errors++;
      $display("FAIL stop_beats_snooze: got %b expected %b", obs, 6'b000_011);
    end
    $display("test_stop_and_snooze done");
  endtask

  task automatic test_key_vs_timeout();
    do_reset();
    start_ring();
    for (int n = 0; n < 59; n++) tick();
    tick_1hz   = 1'b1;
    snooze_key = 1'b1;
    step();
    tick_1hz   = 1'b0;
    snooze_key = 1'b0;
    checks++;
    if (obs !== 6'b010_010) begin
      errors++;
      $display("FAIL key_beats_timeout: got %b expected %b", obs, 6'b010_010);
    end
    $display("test_key_vs_timeout done");
  endtask

  task automatic test_alarm_off();
    do_reset();
    alarm_on = 1'b0;
    set_time(8'h07, 8'h29, 8'h59);
    step();
    set_time(8'h07, 8'h30, 8'h00);
    step();
    checks++;
    if (obs !== 6'b000_011) begin
      errors++;
      $display("FAIL alarm_off_no_ring: got %b expected %b", obs, 6'b000_011);
    end
    set_time(8'h07, 8'h30, 8'h01);
    alarm_on = 1'b1;
    step();
    checks++;
    if (obs !== 6'b000_011) begin
      errors++;
      $display("FAIL arm_late_no_ring: got %b expected %b", obs, 6'b000_011);
    end
    start_ring();
    press_snooze();
    alarm_on = 1'b0;
    step();
    checks++;
    if (obs !== 6'b000_011) begin
      errors++;
      $display("FAIL off_in_snooze: got %b expected %b", obs, 6'b000_011);
    end
    $display("test_alarm_off done");
  endtask

  task automatic test_cr_mid_ring();
    do_reset();
    start_ring();
    tick();
    tick();
    cr = 1'b1;
    set_time(8'h07, 8'h31, 8'h00);
    step();
    checks++;
    if (obs !== 6'b000_011) begin
      errors++;
      $display("FAIL cr_mid_ring: got %b expected %b", obs, 6'b000_011);
    end
    cr = 1'b0;
    start_ring();
    press_snooze();
    cr = 1'b1;
    set_time(8'h07, 8'h31, 8'h00);
    step();
    checks++;
    if (obs !== 6'b000_011) begin
      errors++;
      $display("FAIL cr_mid_snooze: got %b expected %b", obs, 6'b000_011);
    end
    cr = 1'b0;
    $display("test_cr_mid_ring done");
  endtask

  task automatic test_chime();
    do_reset();
    alarm_on = 1'b0;
    set_time(8'h07, 8'h59, 8'h59);
    step();
    checks++;
    if (obs !== 6'b000_011) begin
      errors++;
      $display("FAIL chime_before: got %b expected %b", obs, 6'b000_011);
    end
    set_time(8'h08, 8'h00, 8'h00);
    step();
    checks++;
    if (obs !== {2'b00, CHIME, 3'd3}) begin
      errors++;
      $display("FAIL chime_sec00: got %b expected %b", obs, {2'b00, CHIME, 3'd3});
    end
    set_time(8'h08, 8'h00, 8'h01);
    step();
    checks++;
    if (obs !== {2'b00, CHIME, 3'd3}) begin
      errors++;
      $display("FAIL chime_sec01: got %b expected %b", obs, {2'b00, CHIME, 3'd3});
    end
    set_time(8'h08, 8'h00, 8'h02);
    step();
    checks++;
    if (obs !== 6'b000_011) begin
      errors++;
      $display("FAIL chime_sec02: got %b expected %b", obs, 6'b000_011);
    end
    $display("test_chime done");
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    cr           = 1'b1;
    tick_1hz     = 1'b0;
    alarm_on     = 1'b0;
    stop_key     = 1'b0;
    snooze_key   = 1'b0;
    alarm_hour   = 8'h07;
    alarm_minute = 8'h30;
    set_time(8'h07, 8'h29, 8'h59);

    test_reset();
    test_ring_timeout();
    test_stop();
    test_snooze();
    test_stop_and_snooze();
    test_key_vs_timeout();
    test_alarm_off();
    test_cr_mid_ring();
    test_chime();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
